// File: rtl/instr_stream_loader.sv
// -----------------------------------------------------------------------------
// instr_stream_loader
//
// Boot-time program loader placed in front of the CPU instruction memory.
// Receives a byte-stream frame over a valid/ready interface:
//
//     MAGIC, LEN_LO, LEN_HI, 4*LEN data bytes (each word LSB first), CSUM
//
// where CSUM is the XOR of LEN_LO, LEN_HI and every data byte. Data bytes are
// assembled into little-endian 32-bit words and written to consecutive
// word addresses starting at 0. The CPU is held in reset until the whole frame
// has been written and the checksum matched.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   in_data       stream byte
//   in_valid      in_data valid this cycle
//   in_ready      loader accepts a byte (decoded from state only)
//   reload        one-cycle pulse, restarts loading from DONE or ERROR
//   mem_we        instruction-memory write strobe, one cycle per word
//   mem_addr      word address of the write (held between writes)
//   mem_wdata     assembled word (held between writes)
//   cpu_rst       active-high CPU reset; low only in DONE
//   load_done     program loaded and checksum verified
//   load_err      frame rejected (oversize length or bad checksum)
//   words_loaded  words written in the current frame
// -----------------------------------------------------------------------------
module instr_stream_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  MAGIC      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            csum_q, csum_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           buf_q, buf_d;
    logic [ADDR_WIDTH:0]   wl_q, wl_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  accept;
    logic [15:0]           len_full;
    logic                  last_word;

    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len_q[7:0]};
    // words_loaded lags the write strobe by one cycle, but the next 4th byte is
    // at least three cycles later, so the count is current when it is tested.
    assign last_word = ((33'(wl_q) + 33'd1) == 33'(len_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            csum_q     <= '0;
            byte_idx_q <= '0;
            buf_q      <= '0;
            wl_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            wl_q       <= wl_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        wl_d       = wl_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        // Count advances after the strobe so mem_addr equals words_loaded
        // while mem_we is high.
        if (we_q) begin
            wl_d = wl_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept && (in_data == MAGIC)) begin
                    state_d    = S_LEN_LO;
                    csum_d     = '0;
                    wl_d       = '0;
                    byte_idx_d = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    csum_d     = csum_q ^ in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    csum_d      = csum_q ^ in_data;
                    if (33'(len_full) > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    unique case (byte_idx_q)
                        2'd0: buf_d[7:0]   = in_data;
                        2'd1: buf_d[15:8]  = in_data;
                        2'd2: buf_d[23:16] = in_data;
                        2'd3: begin
                            we_d    = 1'b1;
                            addr_d  = wl_q[ADDR_WIDTH-1:0];
                            wdata_d = {in_data, buf_q};
                            if (last_word) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (reload) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready     = (state_q != S_DONE) && (state_q != S_ERROR);
    assign cpu_rst      = (state_q != S_DONE);
    assign load_done    = (state_q == S_DONE);
    assign load_err     = (state_q == S_ERROR);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
module tb_instr_stream_loader;

    localparam int unsigned AW   = 8;
    localparam int unsigned MAXW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Words of the frame being sent, and the writes seen on the memory port.
    logic [31:0]    fw[$];
    logic [AW+31:0] wr_q[$];

    always #5 clk = ~clk;

    instr_stream_loader #(
        .ADDR_WIDTH(AW),
        .MAGIC     (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .reload      (reload),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_rst     (cpu_rst),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned waited = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_assert++;
            n_fail++;
            $error("FAIL accept_timeout: observed in_ready=0 expected in_ready=1 for byte %0h", b);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    // Sends MAGIC, length, the words in fw and a checksum (optionally
    // corrupted). Stops after the length if the length exceeds capacity.
    task automatic send_frame(input logic [15:0] len, input logic [7:0] flip,
                              input int unsigned gmin, input int unsigned gmax);
        logic [7:0] cs;
        logic [31:0] w;
        wr_q.delete();
        cs = len[7:0] ^ len[15:8];
        send_byte(8'hA5, $urandom_range(gmax, gmin));
        send_byte(len[7:0], $urandom_range(gmax, gmin));
        send_byte(len[15:8], $urandom_range(gmax, gmin));
        if (32'(len) > MAXW) return;
        for (int i = 0; i < int'(len); i++) begin
            w = fw[i];
            for (int j = 0; j < 4; j++) begin
                cs ^= w[8*j +: 8];
                send_byte(w[8*j +: 8], $urandom_range(gmax, gmin));
            end
        end
        send_byte(cs ^ flip, $urandom_range(gmax, gmin));
    endtask

    task automatic check_frame(input string name, input logic [15:0] len, input logic bad_csum);
        logic        ok;
        int unsigned nexp;
        @(negedge clk);
        ok   = (32'(len) <= MAXW) && !bad_csum;
        nexp = (32'(len) > MAXW) ? 0 : 32'(len);
        check({name, "_done"}, load_done, ok);
        check({name, "_err"}, load_err, !ok);
        check({name, "_cpu_rst"}, cpu_rst, !ok);
        check({name, "_in_ready"}, in_ready, 1'b0);
        check({name, "_words_loaded"}, words_loaded, nexp);
        check({name, "_nwrites"}, wr_q.size(), nexp);
        for (int i = 0; i < int'(nexp) && i < wr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), wr_q[i][AW+31:32], i);
            check($sformatf("%s_data%0d", name, i), wr_q[i][31:0], fw[i]);
        end
        if (nexp > 0) begin
            check({name, "_hold_addr"}, mem_addr, nexp - 1);
            check({name, "_hold_data"}, mem_wdata, fw[nexp-1]);
        end
    endtask

    task automatic do_reload(input string name);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check({name, "_rl_in_ready"}, in_ready, 1'b1);
        check({name, "_rl_cpu_rst"}, cpu_rst, 1'b1);
        check({name, "_rl_done"}, load_done, 1'b0);
        check({name, "_rl_err"}, load_err, 1'b0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_cpu_rst"}, cpu_rst, 1'b1);
        check({name, "_mem_we"}, mem_we, 1'b0);
        check({name, "_mem_addr"}, mem_addr, 0);
        check({name, "_mem_wdata"}, mem_wdata, 0);
        check({name, "_done"}, load_done, 1'b0);
        check({name, "_err"}, load_err, 1'b0);
        check({name, "_wl"}, words_loaded, 0);
        check({name, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] len;
        logic [7:0]  flip;

        rst      = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1'b1);

        // Nominal three-word program.
        fw = '{32'h00500513, 32'h00A50533, 32'h0000006F};
        send_frame(16'd3, 8'h00, 0, 0);
        check_frame("nominal", 16'd3, 1'b0);
        do_reload("nominal");

        // Same frame with a corrupted checksum.
        send_frame(16'd3, 8'h01, 0, 0);
        check_frame("badcsum", 16'd3, 1'b1);
        do_reload("badcsum");

        // Oversize length, then a data byte that must not be accepted.
        len = 16'($urandom_range(65535, MAXW + 1));
        send_frame(16'd257, 8'h00, 0, 0);
        check_frame("oversize257", 16'd257, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h13;
        repeat (3) begin
            @(negedge clk);
            check("oversize_refuse_ready", in_ready, 1'b0);
            check("oversize_refuse_err", load_err, 1'b1);
        end
        in_valid = 1'b0;
        do_reload("oversize257");
        send_frame(len, 8'h00, 0, 1);
        check_frame("oversize_rand", len, 1'b0);
        do_reload("oversize_rand");

        // Garbage before MAGIC, then a zero-length frame.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h12, 0);
        @(negedge clk);
        check("garbage_cpu_rst", cpu_rst, 1'b1);
        check("garbage_in_ready", in_ready, 1'b1);
        check("garbage_done", load_done, 1'b0);
        fw.delete();
        send_frame(16'd0, 8'h00, 0, 0);
        check_frame("zerolen", 16'd0, 1'b0);
        do_reload("zerolen");

        // Stalled stream: 5 idle cycles between bytes.
        fw = '{32'h00500513, 32'h00A50533, 32'h0000006F};
        send_frame(16'd3, 8'h00, 5, 5);
        check_frame("stall", 16'd3, 1'b0);
        do_reload("stall");

        // Reset in the middle of the second word.
        wr_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int j = 0; j < 4; j++) send_byte(8'h11 * (j + 1), 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        @(negedge clk);
        check("midframe_wl_before", words_loaded, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        rst = 1'b1;
        fw = '{32'hDEADBEEF, 32'hA5A5A5A5};
        send_frame(16'd2, 8'h00, 0, 2);
        check_frame("after_reset", 16'd2, 1'b0);
        do_reload("after_reset");

        // Capacity boundary: exactly MAX_WORDS words.
        fw.delete();
        for (int i = 0; i < int'(MAXW); i++) fw.push_back((i == 7) ? 32'hA5A5A5A5 : $urandom);
        send_frame(16'(MAXW), 8'h00, 0, 0);
        check_frame("full", 16'(MAXW), 1'b0);
        do_reload("full");

        // Random frames with random stalls and occasional bad checksums.
        for (int k = 0; k < 8; k++) begin
            len = 16'($urandom_range(6, 1));
            flip = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            fw.delete();
            for (int i = 0; i < int'(len); i++) fw.push_back($urandom);
            send_frame(len, flip, 0, 3);
            check_frame($sformatf("rand%0d", k), len, flip != 8'h00);
            do_reload($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
Boot-time program loader that sits directly upstream of the CPU instruction memory. It replaces the bench-side memory preload with a byte-stream frame.
- Accepts bytes over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into instruction memory.
- Holds the CPU in reset until a complete, checksum-verified program has been written.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width. Capacity MAX_WORDS = 2**ADDR_WIDTH.
MAGIC, 8'hA5, frame start byte.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at a rising edge.
reload  input  1  single-cycle pulse; restarts loading from DONE or ERROR.
mem_we  output  1  instruction-memory write strobe, one cycle per word.
mem_addr  output  ADDR_WIDTH  word address of the current write.
mem_wdata  output  32  assembled instruction word.
cpu_rst  output  1  active-high reset to the CPU core; 1 = CPU held.
load_done  output  1  program loaded and verified.
load_err  output  1  frame rejected.
words_loaded  output  ADDR_WIDTH+1  count of words written in the current frame.

Behaviour:
- Frame format: MAGIC, LEN_LO, LEN_HI, then 4*LEN data bytes (each word sent LSB first), then CSUM.
  - LEN is a 16-bit word count.
  - CSUM is the XOR of LEN_LO, LEN_HI and every data byte.
- Reset (rst=0, asynchronous) puts the block in:
  - state IDLE; cpu_rst=1, mem_we=0, mem_addr=0, mem_wdata=0;
  - load_done=0, load_err=0, words_loaded=0;
  - byte index 0, running XOR 0.
- in_ready = 1 in IDLE, LEN_LO, LEN_HI, DATA and CSUM; 0 in DONE and ERROR. It is decoded from state only and never depends on in_valid.
- States (all transitions happen on an accepted byte unless stated):
  - IDLE: MAGIC -> LEN_LO; clear running XOR, words_loaded and byte index. Any other byte is discarded and the state stays IDLE.
  - LEN_LO: latch the low length byte, XOR it in -> LEN_HI.
  - LEN_HI: latch the high byte, XOR it in.
    - LEN > MAX_WORDS -> ERROR.
    - LEN == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: shift the byte into lane (byte index) of the word buffer, XOR it in, increment byte index mod 4.
    - On the 4th byte, the next cycle drives mem_we=1, mem_addr=words_loaded[ADDR_WIDTH-1:0] and mem_wdata=the assembled word, and increments words_loaded.
    - After the last word's 4th byte -> CSUM.
  - CSUM: byte == running XOR -> DONE; otherwise -> ERROR.
  - DONE: cpu_rst=0 and load_done=1 from the cycle after the checksum byte is accepted. Stays in DONE until reload.
  - ERROR: load_err=1 and cpu_rst stays 1. Stays in ERROR until reload.
- reload:
  - In DONE or ERROR, reload -> IDLE on the next edge. cpu_rst returns to 1 and load_done/load_err clear in the same cycle.
  - reload is ignored in every other state.
- mem_we is a single-cycle pulse; there are no back-to-back writes closer than 4 cycles. mem_addr and mem_wdata hold their last values when mem_we=0.
- Stalls: an in_valid gap mid-word preserves byte index, buffer and XOR indefinitely.
- A second MAGIC byte in a non-IDLE state is treated as data, not as a resync.
- Reset mid-frame aborts immediately. Words already written stay in memory, but cpu_rst=1 and the next frame overwrites from address 0.
- cpu_rst is never 0 unless the state is DONE.

Test Plan:
- Nominal load: A5 03 00, words 00500513 / 00A50533 / 0000006F sent LSB first, CSUM = XOR of the length bytes and all 12 data bytes -> three mem_we pulses at addresses 0,1,2 with exactly those words; load_done=1, cpu_rst=0 one cycle after CSUM; words_loaded=3.
- Bad checksum: same frame with CSUM^8'h01 -> all three writes still occur; load_err=1, cpu_rst stays 1, in_ready=0; a reload pulse returns to IDLE with in_ready=1.
- Oversize length: A5 01 01 (LEN=257, ADDR_WIDTH=8) -> ERROR right after LEN_HI, no mem_we; a subsequent data byte is not accepted.
- Zero length and garbage: bytes 00 FF 12 then A5 00 00 00 -> the garbage is discarded, no writes, DONE with words_loaded=0.
- Stall and reset: in_valid gaps of 5 cycles between bytes -> the word is identical to the unstalled case. Then rst=0 mid-word in the second word -> all outputs return to reset values asynchronously; a fresh frame loads from address 0.
- Full load into CPU: a loader-driven exponentiation program with x10 preset to 5 -> after cpu_rst falls, x10 reaches 25.
